// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request sequencer.
// Holds the ALU opcode constants, including the reserved block that starts
// at the idle code 4'b1010, and the FSM state encoding used by alu_arbiter_seq.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    // Driven onto the ALU whenever no operation is in flight; it is also the
    // first reserved code, so 4'b1010..4'b1111 are never executed.
    localparam logic [3:0] OP_IDLE = 4'b1010;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    function automatic logic op_is_reserved(input logic [3:0] op);
        return (op >= OP_IDLE);
    endfunction

endpackage

// File: rtl/alu_arbiter_seq_rr_arb2.sv
// Two-way round-robin grant for the ALU sequencer.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : arbitration allowed this cycle (sequencer idle)
//   valid_i[1:0]   : request valid per requester
//   grant_o[1:0]   : one-hot grant, combinational, zero when en_i is low
// The priority pointer names the requester that wins a tie; it moves to the
// other requester after every grant so back-to-back ties alternate.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic pri_q, pri_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = pri_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

    assign pri_d = (|grant_o) ? ~grant_o[1] : pri_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pri_q <= 1'b0;
        else          pri_q <= pri_d;
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Sequencer that arbitrates two requesters onto one external ALU.
// Ports:
//   clk_i, rst_n_i           : clock, async active-low reset
//   req_valid_i/req_ready_o  : per-requester handshake (bit n = requester n)
//   req_a_i/req_b_i/req_op_i : packed operands/opcodes, requester 1 in upper slice
//   alu_*_o / alu_*_i        : operands+opcode to the ALU, result+flags back
//   rsp_*                    : response channel {id, result, flags, err}
//   busy_o                   : sequencer not idle
//   op_count_o               : completed responses, wrapping
//
// state   | meaning
// IDLE    | ALU parked on OP_IDLE, arbitrate and latch a request
// ISSUE   | latched operands/opcode driven to the ALU
// SETTLE  | ALU inputs held while the result settles
// CAPTURE | ALU inputs held, result and flags registered on exit
// RESP    | response valid, waiting for rsp_ready_i
module alu_arbiter_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [2*(WIDTH+1)-1:0]  req_a_i,
    input  logic [2*(WIDTH+1)-1:0]  req_b_i,
    input  logic [7:0]              req_op_i,
    output logic [WIDTH:0]          alu_a_o,
    output logic [WIDTH:0]          alu_b_o,
    output logic [3:0]              alu_ctrl_o,
    input  logic [WIDTH+1:0]        alu_result_i,
    input  logic                    alu_zero_i,
    input  logic                    alu_carry_i,
    input  logic                    alu_ovf_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_id_o,
    output logic [WIDTH+1:0]        rsp_result_o,
    output logic [2:0]              rsp_flags_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic [7:0]              op_count_o
);

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, b_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic [WIDTH+1:0] result_q;
    logic [2:0]       flags_q;
    logic             err_q;
    logic [7:0]       op_count_q;

    logic [1:0]       grant;
    logic             arb_en;
    logic             gnt_any;
    logic             gnt_idx;
    logic [WIDTH:0]   sel_a, sel_b;
    logic [3:0]       sel_op;
    logic             sel_rsv;
    logic             in_alu_phase;

    assign arb_en = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (arb_en),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign gnt_any     = |grant;
    assign gnt_idx     = grant[1];

    assign sel_a   = gnt_idx ? req_a_i[2*(WIDTH+1)-1:WIDTH+1] : req_a_i[WIDTH:0];
    assign sel_b   = gnt_idx ? req_b_i[2*(WIDTH+1)-1:WIDTH+1] : req_b_i[WIDTH:0];
    assign sel_op  = gnt_idx ? req_op_i[7:4] : req_op_i[3:0];
    assign sel_rsv = op_is_reserved(sel_op);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (gnt_any) state_d = sel_rsv ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Reset wipes the latched request so an aborted operation leaves no trace.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_IDLE;
            id_q       <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (state_q == ST_IDLE && gnt_any) begin
                a_q   <= sel_a;
                b_q   <= sel_b;
                op_q  <= sel_op;
                id_q  <= gnt_idx;
                err_q <= sel_rsv;
                // Reserved codes skip the ALU, so their response is zeroed here.
                if (sel_rsv) begin
                    result_q <= '0;
                    flags_q  <= '0;
                end
            end
            if (state_q == ST_CAPTURE) begin
                result_q <= alu_result_i;
                flags_q  <= {alu_ovf_i, alu_carry_i, alu_zero_i};
            end
            if (state_q == ST_RESP && rsp_ready_i) begin
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    assign in_alu_phase = (state_q == ST_ISSUE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_CAPTURE);

    always_comb begin
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = OP_IDLE;
        if (in_alu_phase) begin
            alu_a_o    = a_q;
            alu_b_o    = b_q;
            alu_ctrl_o = op_q;
        end
    end

    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_flags_o  = flags_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign op_count_o   = op_count_q;

endmodule
